// File: rtl/rgb_hue_sequencer.sv
// rtl/rgb_hue_sequencer.sv - colour-wheel hue sequencer feeding the RGB PWM stage
module rgb_hue_sequencer #(
  parameter int TICK_DIV = 16384,
  parameter int MAXV     = 1023
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic [3:0] bright,
  output logic [9:0] R,
  output logic [9:0] G,
  output logic [9:0] B,
  output logic [2:0] seg,
  output logic       step_tick
);

  localparam int              CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [9:0]      M        = 10'(MAXV);

  logic [CW-1:0] count;
  logic [9:0]    ramp;
  logic [10:0]   sum;
  logic [9:0]    raw_r;
  logic [9:0]    raw_g;
  logic [9:0]    raw_b;

  // Brightness scale: (v * (b+1)) >> 4, product fits in 14 bits.
  function automatic logic [9:0] scale(input logic [9:0] v, input logic [3:0] b);
    logic [13:0] p;
    p = 14'(v) * 14'({1'b0, b} + 5'd1);
    return p[13:4];
  endfunction

  // A step is applied on the last prescaler count only while enabled.
  assign step_tick = enable && (count == CNT_LAST);

  // Step size is 1 << speed; bit 10 of the sum carries into the next segment.
  assign sum = {1'b0, ramp} + (11'd1 << speed);

  // Prescaler: free counts while enabled, holds while frozen.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (enable) begin
      if (count == CNT_LAST) count <= '0;
      else                   count <= count + 1'b1;
    end
  end

  // Ramp/segment advance on each tick; an illegal segment is pulled back to 0.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      ramp <= '0;
      seg  <= '0;
    end else if (step_tick) begin
      ramp <= sum[9:0];
      if (seg > 3'd5)      seg <= 3'd0;
      else if (sum[10])    seg <= (seg == 3'd5) ? 3'd0 : seg + 3'd1;
    end
  end

  // Raw colour for the current position on the wheel; 6/7 behave as segment 0.
  always_comb begin
    raw_r = M;
    raw_g = ramp;
    raw_b = '0;
    case (seg)
      3'd1: begin raw_r = M - ramp; raw_g = M;        raw_b = '0;       end
      3'd2: begin raw_r = '0;       raw_g = M;        raw_b = ramp;     end
      3'd3: begin raw_r = '0;       raw_g = M - ramp; raw_b = M;        end
      3'd4: begin raw_r = ramp;     raw_g = '0;       raw_b = M;        end
      3'd5: begin raw_r = M;        raw_g = '0;       raw_b = M - ramp; end
      default: begin raw_r = M;     raw_g = ramp;     raw_b = '0;       end
    endcase
  end

  // Output register: scaled colour reloaded every clock, one cycle behind seg/ramp.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else begin
      R <= scale(raw_r, bright);
      G <= scale(raw_g, bright);
      B <= scale(raw_b, bright);
    end
  end

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// tb/tb_rgb_hue_sequencer.sv - randomized model-checked bench for rgb_hue_sequencer
module tb_rgb_hue_sequencer;

  localparam int TD = 4;

  logic       clk_100MHz = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] speed;
  logic [3:0] bright;
  logic [9:0] R;
  logic [9:0] G;
  logic [9:0] B;
  logic [2:0] seg;
  logic       step_tick;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: prescaler count and absolute hue position 0..6143.
  int m_cnt;
  int m_pos;
  int e_r;
  int e_g;
  int e_b;

  rgb_hue_sequencer #(.TICK_DIV(TD), .MAXV(1023)) dut (
    .clk_100MHz(clk_100MHz),
    .rst_n(rst_n),
    .enable(enable),
    .speed(speed),
    .bright(bright),
    .R(R),
    .G(G),
    .B(B),
    .seg(seg),
    .step_tick(step_tick)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Colour of a wheel position, channel 0=R 1=G 2=B, at brightness b.
  function automatic int colour(input int pos, input int ch, input int b);
    int s, r, up, dn, v;
    s  = pos / 1024;
    r  = pos % 1024;
    up = r;
    dn = 1023 - r;
    case (ch)
      0: v = (s == 0 || s == 5) ? 1023 : (s == 1) ? dn : (s == 4) ? up : 0;
      1: v = (s == 1 || s == 2) ? 1023 : (s == 0) ? up : (s == 3) ? dn : 0;
      default: v = (s == 3 || s == 4) ? 1023 : (s == 2) ? up : (s == 5) ? dn : 0;
    endcase
    return (v * (b + 1)) / 16;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_pos = 0;
    e_r = 0;
    e_g = 0;
    e_b = 0;
  endtask

  // One clock: drive at negedge, check tick, model the edge, check outputs at negedge.
  task automatic run_cycle(input logic en, input logic [1:0] sp, input logic [3:0] br);
    enable = en;
    speed  = sp;
    bright = br;
    #1;
    check("step_tick", int'(step_tick), (en && m_cnt == TD - 1) ? 1 : 0);
    @(posedge clk_100MHz);
    e_r = colour(m_pos, 0, br);
    e_g = colour(m_pos, 1, br);
    e_b = colour(m_pos, 2, br);
    if (en) begin
      if (m_cnt == TD - 1) begin
        m_cnt = 0;
        m_pos = (m_pos + (1 << sp)) % 6144;
      end else begin
        m_cnt++;
      end
    end
    @(negedge clk_100MHz);
    check("R", int'(R), e_r);
    check("G", int'(G), e_g);
    check("B", int'(B), e_b);
    check("seg", int'(seg), m_pos / 1024);
  endtask

  initial begin
    logic [1:0] sp;
    logic [3:0] br;
    int guard;

    rst_n  = 1'b0;
    enable = 1'b1;
    speed  = 2'd0;
    bright = 4'd15;
    model_reset();
    repeat (3) @(negedge clk_100MHz);
    check("rst_R", int'(R), 0);
    check("rst_G", int'(G), 0);
    check("rst_B", int'(B), 0);
    check("rst_seg", int'(seg), 0);
    check("rst_tick", int'(step_tick), 0);

    rst_n = 1'b1;
    run_cycle(1'b1, 2'd0, 4'd15);
    check("start_R", int'(R), 1023);
    check("start_G", int'(G), 0);

    // Slow stepping through the first few ramp values.
    repeat (16) run_cycle(1'b1, 2'd0, 4'd15);

    // Brightness with no tick: still in segment 0 so raw R is full scale.
    run_cycle(1'b0, 2'd0, 4'd0);
    check("bright0_R", int'(R), 63);
    run_cycle(1'b0, 2'd0, 4'd7);
    check("bright7_R", int'(R), 511);
    run_cycle(1'b0, 2'd0, 4'd15);
    check("bright15_R", int'(R), 1023);

    // Long freeze.
    repeat (100) run_cycle(1'b0, 2'd1, 4'd15);

    // Randomized walk around the wheel.
    sp = 2'd0;
    br = 4'd15;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 49) == 0) sp = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) br = 4'($urandom_range(0, 15));
      run_cycle($urandom_range(0, 9) != 0, sp, br);
    end

    // Advance to segment 3, then reset asynchronously between edges.
    guard = 0;
    while (m_pos / 1024 != 3 && guard < 20000) begin
      run_cycle(1'b1, 2'd3, 4'd15);
      guard++;
    end
    check("reach_seg3", m_pos / 1024, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_R", int'(R), 0);
    check("async_G", int'(G), 0);
    check("async_B", int'(B), 0);
    check("async_seg", int'(seg), 0);
    model_reset();
    @(negedge clk_100MHz);
    rst_n = 1'b1;
    run_cycle(1'b1, 2'd0, 4'd15);
    check("resume_R", int'(R), 1023);
    repeat (40) run_cycle(1'b1, 2'd2, 4'd15);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
